// File: rtl/hex_pkg.sv
// hex_pkg: shared seven-segment definitions for the hex counter display path.
//   - segment bit order (a at bit 0 .. g at bit 6)
//   - active-low glyph constants SEG_0..SEG_F and SEG_BLANK
//   - seg_glyph(): nibble to glyph lookup
package hex_pkg;

  // Bit position of each segment within a 7-bit digit slice.
  typedef enum int {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F_BIT = 5,
    SEG_G = 6
  } seg_bit_e;

  // Glyphs are written {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A_GLYPH = 7'b0001000;
  localparam logic [6:0] SEG_B_GLYPH = 7'b0000011;  // lowercase b
  localparam logic [6:0] SEG_C_GLYPH = 7'b1000110;
  localparam logic [6:0] SEG_D_GLYPH = 7'b0100001;  // lowercase d
  localparam logic [6:0] SEG_E_GLYPH = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_glyph(input logic [3:0] nibble);
    logic [6:0] g;
    g = SEG_BLANK;
    case (nibble)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A_GLYPH;
      4'hB: g = SEG_B_GLYPH;
      4'hC: g = SEG_C_GLYPH;
      4'hD: g = SEG_D_GLYPH;
      4'hE: g = SEG_E_GLYPH;
      4'hF: g = SEG_F;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// hex7seg: one hex digit to active-low seven-segment decode, purely combinational.
//   nibble : 4-bit digit value
//   seg    : segments {g,f,e,d,c,b,a}, 0 = lit
module hex7seg
  import hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_glyph(nibble);
  end

endmodule

// File: rtl/hex_counter_n.sv
// hex_counter_n: up/down counter with synchronous load, wrap or saturate at a
// programmable modulus, and active-low seven-segment decode of every digit.
//   clock      : rising-edge clock
//   clear      : asynchronous active-high reset, count -> 0
//   enable     : count enable
//   up         : 1 = increment, 0 = decrement
//   load       : synchronous load strobe (clamped to MODULUS-1)
//   load_value : value to load
//   count      : registered count
//   tc         : terminal count, combinational, cascades into next enable
//   hex        : DIGITS x 7 segment outputs, digit 0 in hex[6:0]
module hex_counter_n
  import hex_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter int              SATURATE = 0,
  localparam int             DIGITS   = WIDTH / 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic [7*DIGITS-1:0]   hex
);

  // One extra bit so MODULUS = 2**WIDTH stays representable in the compare.
  localparam logic [WIDTH:0]   MOD_W     = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_max;
  logic             at_zero;
  logic             load_in_range;

  assign at_max        = (count_q == COUNT_MAX);
  assign at_zero       = (count_q == '0);
  assign load_in_range = ({1'b0, load_value} < MOD_W);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_in_range ? load_value : COUNT_MAX;
    end else if (enable) begin
      if (up) begin
        if (!at_max)            count_d = count_q + 1'b1;
        else if (SATURATE == 0) count_d = '0;
      end else begin
        if (!at_zero)           count_d = count_q - 1'b1;
        else if (SATURATE == 0) count_d = COUNT_MAX;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

  // Reported at the range end even when saturating, so cascades still see it.
  assign tc = enable & ~load & (up ? at_max : at_zero);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    hex7seg u_hex7seg (
      .nibble (count_q[4*k +: 4]),
      .seg    (hex[7*k +: 7])
    );
  end

endmodule

// File: tb/tb_hex_counter_n.sv
module tb_hex_counter_n;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        enable = 1'b0;
  logic        up = 1'b0;
  logic        load = 1'b0;
  logic [15:0] lv = '0;

  logic [7:0]  cnt0;  logic tc0;  logic [13:0] hex0;
  logic [3:0]  cnt1;  logic tc1;  logic [6:0]  hex1;
  logic [7:0]  cnt2;  logic tc2;  logic [13:0] hex2;
  logic [15:0] cnt3;  logic tc3;  logic [27:0] hex3;

  always #5 clock = ~clock;

  hex_counter_n #(.WIDTH(8)) u_def (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(lv[7:0]), .count(cnt0), .tc(tc0), .hex(hex0));
  hex_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_dec (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(lv[3:0]), .count(cnt1), .tc(tc1), .hex(hex1));
  hex_counter_n #(.WIDTH(8), .MODULUS(100), .SATURATE(1)) u_sat (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(lv[7:0]), .count(cnt2), .tc(tc2), .hex(hex2));
  hex_counter_n #(.WIDTH(16)) u_w16 (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(lv), .count(cnt3), .tc(tc3), .hex(hex3));

  logic [31:0] cnt_a [4];
  logic        tc_a  [4];
  logic [27:0] hex_a [4];
  assign cnt_a[0] = 32'(cnt0); assign tc_a[0] = tc0; assign hex_a[0] = 28'(hex0);
  assign cnt_a[1] = 32'(cnt1); assign tc_a[1] = tc1; assign hex_a[1] = 28'(hex1);
  assign cnt_a[2] = 32'(cnt2); assign tc_a[2] = tc2; assign hex_a[2] = 28'(hex2);
  assign cnt_a[3] = 32'(cnt3); assign tc_a[3] = tc3; assign hex_a[3] = 28'(hex3);

  // Reference model: one integer count per instance, stepped by the stated rules.
  int mod_a [4] = '{256, 10, 100, 65536};
  bit sat_a [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int dig_a [4] = '{2, 1, 2, 4};
  int m     [4] = '{0, 0, 0, 0};

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;

  function automatic logic [27:0] exp_hex(input int value, input int digits);
    logic [27:0] h = '0;
    for (int k = 0; k < digits; k++) h[7*k +: 7] = glyph[(value >> (4*k)) & 15];
    return h;
  endfunction

  function automatic logic exp_tc(input int i);
    if (!enable || load) return 1'b0;
    return up ? (m[i] == mod_a[i] - 1) : (m[i] == 0);
  endfunction

  task automatic cycle();
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      int lvi = int'(lv) & ((1 << (4*dig_a[i])) - 1);
      if (clear) m[i] = 0;
      else if (load) m[i] = (lvi < mod_a[i]) ? lvi : mod_a[i] - 1;
      else if (enable) begin
        if (up) m[i] = (m[i] == mod_a[i] - 1) ? (sat_a[i] ? m[i] : 0) : m[i] + 1;
        else    m[i] = (m[i] == 0) ? (sat_a[i] ? 0 : mod_a[i] - 1) : m[i] - 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    enable = 1'b1; up = 1'b0; load = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      checks++; if (cnt_a[i] !== 32'd0) begin errors++; $display("FAIL reset_count[%0d] got %0h want 0", i, cnt_a[i]); end
      checks++; if (hex_a[i] !== exp_hex(0, dig_a[i])) begin errors++; $display("FAIL reset_hex[%0d] got %0h want %0h", i, hex_a[i], exp_hex(0, dig_a[i])); end
      checks++; if (tc_a[i] !== 1'b1) begin errors++; $display("FAIL reset_tc_down[%0d] got %b want 1", i, tc_a[i]); end
    end
    up = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (tc_a[i] !== 1'b0) begin errors++; $display("FAIL reset_tc_up[%0d] got %b want 0", i, tc_a[i]); end
    end
    up = 1'b0; load = 1'b1; #1;
    checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL reset_tc_load got %b want 0", tc0); end
    load = 1'b0; enable = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    cycle();
  endtask

  task automatic test_wrap_up();
    int tc_hits = 0;
    enable = 1'b1; up = 1'b1; load = 1'b0;
    for (int n = 0; n < 256; n++) begin
      #1;
      if (tc0) tc_hits++;
      for (int i = 0; i < 4; i++) begin
        checks++; if (cnt_a[i] !== 32'(m[i])) begin errors++; $display("FAIL wrap_count[%0d] got %0h want %0h", i, cnt_a[i], m[i]); end
        checks++; if (tc_a[i] !== exp_tc(i)) begin errors++; $display("FAIL wrap_tc[%0d] got %b want %b", i, tc_a[i], exp_tc(i)); end
      end
      checks++; if (tc0 !== (cnt0 == 8'hFF)) begin errors++; $display("FAIL wrap_tc_ff got %b at count %0h", tc0, cnt0); end
      cycle();
    end
    checks++; if (cnt0 !== 8'h00) begin errors++; $display("FAIL wrap_end_count got %0h want 00", cnt0); end
    checks++; if (hex0 !== {7'b1000000, 7'b1000000}) begin errors++; $display("FAIL wrap_end_hex got %0h want %0h", hex0, {7'b1000000, 7'b1000000}); end
    checks++; if (tc_hits != 1) begin errors++; $display("FAIL wrap_tc_hits got %0d want 1", tc_hits); end
  endtask

  task automatic test_decimal_wrap();
    clear = 1'b1; #1; clear = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = 0;
    enable = 1'b1; up = 1'b0; load = 1'b0;
    #1;
    checks++; if (tc1 !== 1'b1) begin errors++; $display("FAIL dec_tc_at0 got %b want 1", tc1); end
    cycle();
    checks++; if (cnt1 !== 4'd9) begin errors++; $display("FAIL dec_down_wrap got %0d want 9", cnt1); end
    checks++; if (hex1 !== 7'b0010000) begin errors++; $display("FAIL dec_hex9 got %b want 0010000", hex1); end
    up = 1'b1; #1;
    checks++; if (tc1 !== 1'b1) begin errors++; $display("FAIL dec_tc_at9 got %b want 1", tc1); end
    cycle();
    checks++; if (cnt1 !== 4'd0) begin errors++; $display("FAIL dec_up_wrap got %0d want 0", cnt1); end
  endtask

  task automatic test_saturate();
    int exp_seq [5] = '{98, 99, 99, 99, 99};
    load = 1'b1; lv = 16'd98; enable = 1'b0;
    cycle();
    load = 1'b0; enable = 1'b1; up = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++; if (cnt2 !== 8'(exp_seq[n])) begin errors++; $display("FAIL sat_count[%0d] got %0d want %0d", n, cnt2, exp_seq[n]); end
      checks++; if (tc2 !== (exp_seq[n] == 99)) begin errors++; $display("FAIL sat_tc[%0d] got %b want %b", n, tc2, exp_seq[n] == 99); end
      cycle();
    end
  endtask

  task automatic test_load_clamp();
    load = 1'b1; enable = 1'b1; up = 1'b1; lv = 16'd200;
    #1;
    checks++; if (tc2 !== 1'b0) begin errors++; $display("FAIL clamp_tc got %b want 0", tc2); end
    cycle();
    checks++; if (cnt2 !== 8'd99) begin errors++; $display("FAIL clamp_count got %0d want 99", cnt2); end
    checks++; if (cnt1 !== 4'd8) begin errors++; $display("FAIL clamp_dec_count got %0d want 8", cnt1); end
    checks++; if (cnt0 !== 8'd200) begin errors++; $display("FAIL clamp_def_count got %0d want 200", cnt0); end
  endtask

  task automatic test_async_clear();
    load = 1'b1; lv = 16'h005A; enable = 1'b0;
    cycle();
    checks++; if (cnt0 !== 8'h5A) begin errors++; $display("FAIL aclr_preload got %0h want 5a", cnt0); end
    load = 1'b0; enable = 1'b1; up = 1'b1;
    #3;
    load = 1'b1; lv = 16'(($urandom % 200) + 1);
    clear = 1'b1;
    for (int i = 0; i < 4; i++) m[i] = 0;
    #1;
    checks++; if (cnt0 !== 8'h00) begin errors++; $display("FAIL aclr_immediate got %0h want 00", cnt0); end
    checks++; if (hex0 !== {7'b1000000, 7'b1000000}) begin errors++; $display("FAIL aclr_hex got %0h want %0h", hex0, {7'b1000000, 7'b1000000}); end
    cycle();
    for (int i = 0; i < 4; i++) begin
      checks++; if (cnt_a[i] !== 32'd0) begin errors++; $display("FAIL aclr_hold[%0d] got %0h want 0", i, cnt_a[i]); end
    end
    @(negedge clock);
    clear = 1'b0; load = 1'b0;
    cycle();
    checks++; if (cnt0 !== 8'h01) begin errors++; $display("FAIL aclr_resume got %0h want 01", cnt0); end
  endtask

  task automatic test_decode_sweep();
    logic [15:0] vals [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    enable = 1'b0; load = 1'b1;
    for (int v = 0; v < 4; v++) begin
      lv = vals[v];
      cycle();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (hex3[7*k +: 7] !== glyph[(vals[v] >> (4*k)) & 16'hF]) begin
          errors++;
          $display("FAIL decode_%0h_digit%0d got %b want %b", vals[v], k, hex3[7*k +: 7], glyph[(vals[v] >> (4*k)) & 16'hF]);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      enable = ($urandom % 4) != 0;
      up     = $urandom % 2;
      load   = ($urandom % 10) == 0;
      case ($urandom % 4)
        0:       lv = 16'($urandom);
        1:       lv = 16'($urandom % 12);
        2:       lv = 16'(96 + $urandom % 8);
        default: lv = 16'(16'hFFFF - $urandom % 4);
      endcase
      #1;
      for (int i = 0; i < 4; i++) begin
        checks++; if (cnt_a[i] !== 32'(m[i])) begin errors++; $display("FAIL rand_count[%0d] n=%0d got %0h want %0h", i, n, cnt_a[i], m[i]); end
        checks++; if (tc_a[i] !== exp_tc(i)) begin errors++; $display("FAIL rand_tc[%0d] n=%0d got %b want %b", i, n, tc_a[i], exp_tc(i)); end
        checks++; if (hex_a[i] !== exp_hex(m[i], dig_a[i])) begin errors++; $display("FAIL rand_hex[%0d] n=%0d got %0h want %0h", i, n, hex_a[i], exp_hex(m[i], dig_a[i])); end
      end
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_decimal_wrap();
    test_saturate();
    test_load_clamp();
    test_async_clear();
    test_decode_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
